// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller:
// state encoding, piezo event codes and default coin/stock values.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_CHANGE,
    ST_ADMIN
  } state_t;

  localparam logic [3:0] EVT_NONE     = 4'd0;
  localparam logic [3:0] EVT_COIN     = 4'd1;
  localparam logic [3:0] EVT_VEND     = 4'd2;
  localparam logic [3:0] EVT_SOLDOUT  = 4'd3;
  localparam logic [3:0] EVT_NOFUND   = 4'd4;
  localparam logic [3:0] EVT_CHG_DONE = 4'd5;
  localparam logic [3:0] EVT_ERR      = 4'd6;
  localparam logic [3:0] EVT_RESTOCK  = 4'd7;
  localparam logic [3:0] EVT_ADMIN    = 4'd8;

  localparam int DEF_COIN_S_VAL = 1;
  localparam int DEF_COIN_L_VAL = 5;
  localparam int DEF_MAX_CREDIT = 20;
  localparam int DEF_INIT_STOCK = 2;
  localparam int DEF_MAX_STOCK  = 9;

endpackage

// File: rtl/vending_core_change_dispenser.sv
// Change sequencer: while load is high, pays out one coin per cycle
// (large when it fits, else small). Ports: clk, rst, load, credit in;
// credit_nxt (remaining after this cycle's coin), chg_s, chg_l, done out.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int MONEY_W    = 8,
  parameter int COIN_S_VAL = DEF_COIN_S_VAL,
  parameter int COIN_L_VAL = DEF_COIN_L_VAL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MONEY_W-1:0] credit,
  output logic [MONEY_W-1:0] credit_nxt,
  output logic               chg_s,
  output logic               chg_l,
  output logic               done
);

  logic               use_l;
  logic [MONEY_W-1:0] dec;

  always_comb begin
    use_l = credit >= MONEY_W'(COIN_L_VAL);
    dec   = '0;
    if (use_l)
      dec = MONEY_W'(COIN_L_VAL);
    else if (credit >= MONEY_W'(COIN_S_VAL))
      dec = MONEY_W'(COIN_S_VAL);
    else
      // odd remainder below the small coin: pay it as one last coin
      dec = credit;
    credit_nxt = credit - dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg_s <= 1'b0;
      chg_l <= 1'b0;
      done  <= 1'b0;
    end else begin
      chg_l <= load & use_l;
      chg_s <= load & ~use_l;
      done  <= load & (credit_nxt == '0);
    end
  end

endmodule

// File: rtl/vending_core.sv
// Vending controller: coin credit, product select/vend, change payout,
// admin restock. Outputs credit, stock, vend/change/reject/event pulses.
module vending_core
  import vending_pkg::*;
#(
  parameter int NUM_PROD   = 4,
  parameter int MONEY_W    = 8,
  parameter int STOCK_W    = 4,
  parameter logic [NUM_PROD*MONEY_W-1:0] PRICES =
    {8'd9, 8'd7, 8'd5, 8'd3},
  parameter int COIN_S_VAL = DEF_COIN_S_VAL,
  parameter int COIN_L_VAL = DEF_COIN_L_VAL,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT,
  parameter int INIT_STOCK = DEF_INIT_STOCK,
  parameter int MAX_STOCK  = DEF_MAX_STOCK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        coin_s,
  input  logic                        coin_l,
  input  logic [NUM_PROD-1:0]         sel,
  input  logic                        ret,
  input  logic                        admin_tgl,
  output logic [MONEY_W-1:0]          credit,
  output logic [NUM_PROD*STOCK_W-1:0] stock,
  output logic                        vend_valid,
  output logic [2:0]                  vend_id,
  output logic                        chg_s,
  output logic                        chg_l,
  output logic                        coin_reject,
  output logic                        evt_valid,
  output logic [3:0]                  evt_code,
  output logic                        admin_mode
);

  localparam int SUM_W = MONEY_W + 1;

  state_t                             state;
  logic [MONEY_W-1:0]                 credit_q;
  logic [NUM_PROD-1:0][STOCK_W-1:0]   stock_q;
  logic                               evt_vq;
  logic [3:0]                         evt_cq;

  logic [SUM_W-1:0]   sum_s;
  logic [SUM_W-1:0]   sum_l;
  logic               fit_s;
  logic               fit_l;
  logic               coin_any;
  logic               coin_acc;
  logic               coin_rej;
  logic [MONEY_W-1:0] coin_val;
  logic               sel_any;
  logic               sel_one;
  logic [2:0]         sel_idx;
  logic [MONEY_W-1:0] price;
  logic [STOCK_W-1:0] sel_stock;
  logic [MONEY_W-1:0] remain;
  logic               admin_go;
  logic               blocked;

  logic [MONEY_W-1:0] chg_rem;
  logic               chg_done;

  change_dispenser #(
    .MONEY_W   (MONEY_W),
    .COIN_S_VAL(COIN_S_VAL),
    .COIN_L_VAL(COIN_L_VAL)
  ) u_chg (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ST_CHANGE),
    .credit    (credit_q),
    .credit_nxt(chg_rem),
    .chg_s     (chg_s),
    .chg_l     (chg_l),
    .done      (chg_done)
  );

  always_comb begin
    sum_s = {1'b0, credit_q} + SUM_W'(COIN_S_VAL);
    sum_l = {1'b0, credit_q} + SUM_W'(COIN_L_VAL);
    fit_s = sum_s <= SUM_W'(MAX_CREDIT);
    fit_l = sum_l <= SUM_W'(MAX_CREDIT);
    coin_any = coin_s | coin_l;
    coin_acc = 1'b0;
    coin_val = '0;
    // large coin wins a tie; the small one is always refused then
    if (coin_l) begin
      coin_acc = fit_l;
      coin_val = MONEY_W'(COIN_L_VAL);
    end else if (coin_s) begin
      coin_acc = fit_s;
      coin_val = MONEY_W'(COIN_S_VAL);
    end
    coin_rej = (coin_l & ~fit_l)
             | (coin_l & coin_s)
             | (coin_s & ~coin_l & ~fit_s);
  end

  always_comb begin
    sel_idx   = '0;
    price     = '0;
    sel_stock = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel[i]) begin
        sel_idx   = 3'(i);
        price     = PRICES[i*MONEY_W +: MONEY_W];
        sel_stock = stock_q[i];
      end
    end
    sel_any  = |sel;
    sel_one  = $onehot(sel);
    remain   = credit_q - price;
    admin_go = admin_tgl & (state == ST_IDLE);
    blocked  = ret | sel_any | admin_go;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      credit_q   <= '0;
      for (int i = 0; i < NUM_PROD; i++)
        stock_q[i] <= STOCK_W'(INIT_STOCK);
      vend_valid  <= 1'b0;
      vend_id     <= '0;
      coin_reject <= 1'b0;
      evt_vq      <= 1'b0;
      evt_cq      <= EVT_NONE;
      admin_mode  <= 1'b0;
    end else begin
      vend_valid  <= 1'b0;
      coin_reject <= 1'b0;
      evt_vq      <= 1'b0;
      unique case (state)
        ST_IDLE, ST_CREDIT: begin
          coin_reject <= blocked ? coin_any : coin_rej;
          if (ret) begin
            if (state == ST_CREDIT)
              state <= ST_CHANGE;
          end else if (admin_go) begin
            state      <= ST_ADMIN;
            admin_mode <= 1'b1;
            evt_vq     <= 1'b1;
            evt_cq     <= EVT_ADMIN;
          end else if (sel_any) begin
            evt_vq <= 1'b1;
            if (!sel_one) begin
              evt_cq <= EVT_ERR;
            end else if (sel_stock == '0) begin
              evt_cq <= EVT_SOLDOUT;
            end else if (credit_q < price) begin
              evt_cq <= EVT_NOFUND;
            end else begin
              evt_cq     <= EVT_VEND;
              credit_q   <= remain;
              vend_valid <= 1'b1;
              vend_id    <= sel_idx;
              for (int i = 0; i < NUM_PROD; i++)
                if (sel[i])
                  stock_q[i] <= stock_q[i] - 1'b1;
              state <= (remain != '0) ? ST_CHANGE : ST_IDLE;
            end
          end else if (coin_acc) begin
            credit_q <= credit_q + coin_val;
            state    <= ST_CREDIT;
            evt_vq   <= 1'b1;
            evt_cq   <= EVT_COIN;
          end
        end
        ST_CHANGE: begin
          credit_q <= chg_rem;
          if (chg_rem == '0)
            state <= ST_IDLE;
        end
        ST_ADMIN: begin
          coin_reject <= coin_any;
          if (admin_tgl) begin
            state      <= ST_IDLE;
            admin_mode <= 1'b0;
            evt_vq     <= 1'b1;
            evt_cq     <= EVT_ADMIN;
          end else if (sel_any) begin
            for (int i = 0; i < NUM_PROD; i++)
              if (sel[i] && stock_q[i] < STOCK_W'(MAX_STOCK))
                stock_q[i] <= stock_q[i] + 1'b1;
            evt_vq <= 1'b1;
            evt_cq <= EVT_RESTOCK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // the dispenser's done pulse carries the CHG_DONE event; the core
  // itself never raises an event while paying out change
  assign credit    = credit_q;
  assign stock     = stock_q;
  assign evt_valid = evt_vq | chg_done;
  assign evt_code  = chg_done ? EVT_CHG_DONE : evt_cq;

endmodule

// File: tb/tb_vending_core.sv
// Directed bench for vending_core: coins, vend, change, reject,
// soldout/nofund/err, admin restock and reset during change.
module tb_vending_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coin_s = 1'b0;
  logic        coin_l = 1'b0;
  logic [3:0]  sel = '0;
  logic        ret = 1'b0;
  logic        admin_tgl = 1'b0;
  logic [7:0]  credit;
  logic [15:0] stock;
  logic        vend_valid;
  logic [2:0]  vend_id;
  logic        chg_s;
  logic        chg_l;
  logic        coin_reject;
  logic        evt_valid;
  logic [3:0]  evt_code;
  logic        admin_mode;

  int total = 0;
  int bad = 0;

  vending_core dut (
    .clk        (clk),
    .rst        (rst),
    .coin_s     (coin_s),
    .coin_l     (coin_l),
    .sel        (sel),
    .ret        (ret),
    .admin_tgl  (admin_tgl),
    .credit     (credit),
    .stock      (stock),
    .vend_valid (vend_valid),
    .vend_id    (vend_id),
    .chg_s      (chg_s),
    .chg_l      (chg_l),
    .coin_reject(coin_reject),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .admin_mode (admin_mode)
  );

  always #5 clk = ~clk;

  // apply inputs for one clock, sample 1ns after the edge
  task automatic step(input logic cs, input logic cl,
                      input logic [3:0] s, input logic r,
                      input logic a, input logic rs);
    coin_s = cs; coin_l = cl; sel = s;
    ret = r; admin_tgl = a; rst = rs;
    @(posedge clk);
    #1;
    coin_s = 0; coin_l = 0; sel = '0;
    ret = 0; admin_tgl = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 4'h0, 0, 0, 1);
    total++; if (credit !== 8'd0) begin bad++; $display("FAIL rst_credit got=%0d exp=0", credit); end
    total++; if (stock !== 16'h2222) begin bad++; $display("FAIL rst_stock got=%h exp=2222", stock); end
    total++; if ({vend_valid, chg_s, chg_l, coin_reject, evt_valid, admin_mode} !== 6'b0) begin
      bad++; $display("FAIL rst_pulses got=%b exp=000000",
        {vend_valid, chg_s, chg_l, coin_reject, evt_valid, admin_mode});
    end
  endtask

  task automatic test_vend_change();
    step(0, 1, 4'h0, 0, 0, 0);
    total++; if (credit !== 8'd5) begin bad++; $display("FAIL vc_credit5 got=%0d exp=5", credit); end
    total++; if (evt_valid !== 1'b1 || evt_code !== 4'd1) begin bad++; $display("FAIL vc_evt_coin got=%b/%0d exp=1/1", evt_valid, evt_code); end
    step(1, 0, 4'h0, 0, 0, 0);
    total++; if (credit !== 8'd6) begin bad++; $display("FAIL vc_credit6 got=%0d exp=6", credit); end
    step(0, 0, 4'b0010, 0, 0, 0);
    total++; if (vend_valid !== 1'b1 || vend_id !== 3'd1) begin bad++; $display("FAIL vc_vend got=%b/%0d exp=1/1", vend_valid, vend_id); end
    total++; if (credit !== 8'd1) begin bad++; $display("FAIL vc_credit1 got=%0d exp=1", credit); end
    total++; if (stock !== 16'h2212) begin bad++; $display("FAIL vc_stock got=%h exp=2212", stock); end
    total++; if (evt_code !== 4'd2) begin bad++; $display("FAIL vc_evt_vend got=%0d exp=2", evt_code); end
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if (chg_s !== 1'b1 || chg_l !== 1'b0) begin bad++; $display("FAIL vc_chg got=%b%b exp=10", chg_s, chg_l); end
    total++; if (credit !== 8'd0) begin bad++; $display("FAIL vc_credit0 got=%0d exp=0", credit); end
    total++; if (evt_valid !== 1'b1 || evt_code !== 4'd5) begin bad++; $display("FAIL vc_chg_done got=%b/%0d exp=1/5", evt_valid, evt_code); end
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if (chg_s !== 1'b0 || evt_valid !== 1'b0) begin bad++; $display("FAIL vc_quiet got=%b%b exp=00", chg_s, evt_valid); end
  endtask

  task automatic test_full_change();
    logic [1:0] exp_l;
    logic [7:0] exp_c;
    logic [4:0] pat_l;
    logic [39:0] pat_c;
    pat_l = 5'b00111;
    pat_c = {8'd0, 8'd1, 8'd2, 8'd7, 8'd12};
    for (int i = 0; i < 4; i++) step(0, 1, 4'h0, 0, 0, 0);
    total++; if (credit !== 8'd20) begin bad++; $display("FAIL fc_credit20 got=%0d exp=20", credit); end
    step(0, 0, 4'b0001, 0, 0, 0);
    total++; if (credit !== 8'd17 || vend_id !== 3'd0) begin bad++; $display("FAIL fc_vend got=%0d/%0d exp=17/0", credit, vend_id); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'h0, 0, 0, 0);
      exp_l = {~pat_l[i], pat_l[i]};
      exp_c = pat_c[i*8 +: 8];
      total++;
      if ({chg_s, chg_l} !== exp_l || credit !== exp_c) begin
        bad++; $display("FAIL fc_coin%0d got=%b%b/%0d exp=%b/%0d", i, chg_s, chg_l, credit, exp_l, exp_c);
      end
    end
    total++; if (evt_code !== 4'd5) begin bad++; $display("FAIL fc_done got=%0d exp=5", evt_code); end
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if ({chg_s, chg_l} !== 2'b00) begin bad++; $display("FAIL fc_stop got=%b%b exp=00", chg_s, chg_l); end
  endtask

  task automatic test_reject();
    for (int i = 0; i < 4; i++) step(0, 1, 4'h0, 0, 0, 0);
    total++; if (credit !== 8'd20 || coin_reject !== 1'b0) begin bad++; $display("FAIL rj_fill got=%0d/%b exp=20/0", credit, coin_reject); end
    step(1, 0, 4'h0, 0, 0, 0);
    total++; if (coin_reject !== 1'b1 || credit !== 8'd20) begin bad++; $display("FAIL rj_small got=%b/%0d exp=1/20", coin_reject, credit); end
    step(1, 1, 4'h0, 0, 0, 0);
    total++; if (coin_reject !== 1'b1 || credit !== 8'd20) begin bad++; $display("FAIL rj_both got=%b/%0d exp=1/20", coin_reject, credit); end
    step(0, 0, 4'h0, 1, 0, 0);
    total++; if (chg_l !== 1'b0 || credit !== 8'd20) begin bad++; $display("FAIL rj_ret got=%b/%0d exp=0/20", chg_l, credit); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'h0, 0, 0, 0);
      total++;
      if (chg_l !== 1'b1 || credit !== 8'(15 - 5 * i)) begin
        bad++; $display("FAIL rj_payout%0d got=%b/%0d exp=1/%0d", i, chg_l, credit, 15 - 5 * i);
      end
    end
    total++; if (evt_code !== 4'd5) begin bad++; $display("FAIL rj_done got=%0d exp=5", evt_code); end
  endtask

  task automatic test_soldout();
    step(0, 1, 4'h0, 0, 0, 0);
    step(0, 0, 4'b0001, 0, 0, 0);
    total++; if (credit !== 8'd2 || stock !== 16'h2210) begin bad++; $display("FAIL so_buy got=%0d/%h exp=2/2210", credit, stock); end
    step(0, 0, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if (credit !== 8'd0 || chg_s !== 1'b1) begin bad++; $display("FAIL so_change got=%0d/%b exp=0/1", credit, chg_s); end
    step(0, 1, 4'h0, 0, 0, 0);
    step(0, 0, 4'b0001, 0, 0, 0);
    total++; if (evt_code !== 4'd3 || credit !== 8'd5 || vend_valid !== 1'b0) begin
      bad++; $display("FAIL so_soldout got=%0d/%0d/%b exp=3/5/0", evt_code, credit, vend_valid);
    end
    step(0, 0, 4'b1000, 0, 0, 0);
    total++; if (evt_code !== 4'd4 || credit !== 8'd5) begin bad++; $display("FAIL so_nofund got=%0d/%0d exp=4/5", evt_code, credit); end
    step(0, 0, 4'b0011, 0, 0, 0);
    total++; if (evt_code !== 4'd6 || credit !== 8'd5 || stock !== 16'h2210) begin
      bad++; $display("FAIL so_err got=%0d/%0d/%h exp=6/5/2210", evt_code, credit, stock);
    end
    step(0, 1, 4'b0010, 0, 0, 0);
    total++; if (vend_valid !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd0 || stock !== 16'h2200) begin
      bad++; $display("FAIL so_prio got=%b/%b/%0d/%h exp=1/1/0/2200", vend_valid, coin_reject, credit, stock);
    end
    step(0, 0, 4'h0, 1, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if (chg_s !== 1'b0 || chg_l !== 1'b0 || credit !== 8'd0) begin
      bad++; $display("FAIL so_ret_idle got=%b%b/%0d exp=00/0", chg_s, chg_l, credit);
    end
  endtask

  task automatic test_admin();
    step(0, 0, 4'h0, 0, 1, 0);
    total++; if (admin_mode !== 1'b1 || evt_code !== 4'd8) begin bad++; $display("FAIL ad_enter got=%b/%0d exp=1/8", admin_mode, evt_code); end
    step(1, 0, 4'h0, 0, 0, 0);
    total++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin bad++; $display("FAIL ad_coin got=%b/%0d exp=1/0", coin_reject, credit); end
    for (int i = 0; i < 9; i++) step(0, 0, 4'b0100, 0, 0, 0);
    total++; if (stock !== 16'h2900 || evt_code !== 4'd7) begin bad++; $display("FAIL ad_restock got=%h/%0d exp=2900/7", stock, evt_code); end
    step(0, 0, 4'h0, 0, 1, 0);
    total++; if (admin_mode !== 1'b0) begin bad++; $display("FAIL ad_exit got=%b exp=0", admin_mode); end
  endtask

  task automatic test_reset_change();
    step(0, 1, 4'h0, 0, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0, 0);
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if (chg_l !== 1'b1 || credit !== 8'd5) begin bad++; $display("FAIL rc_first got=%b/%0d exp=1/5", chg_l, credit); end
    step(0, 0, 4'h0, 0, 0, 1);
    total++; if ({chg_s, chg_l} !== 2'b00 || credit !== 8'd0 || stock !== 16'h2222) begin
      bad++; $display("FAIL rc_reset got=%b%b/%0d/%h exp=00/0/2222", chg_s, chg_l, credit, stock);
    end
    step(0, 0, 4'h0, 0, 0, 0);
    total++; if ({chg_s, chg_l, evt_valid} !== 3'b000 || credit !== 8'd0) begin
      bad++; $display("FAIL rc_idle got=%b%b%b/%0d exp=000/0", chg_s, chg_l, evt_valid, credit);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vend_change();
    test_full_change();
    test_reject();
    test_soldout();
    test_admin();
    test_reset_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
